// File: rtl/ex_div_seq_pkg.sv
// Shared definitions for the execute-stage divide sequencer: op bit positions,
// FSM state encodings and the iteration count.
package ex_div_seq_pkg;

  localparam int DIV_SIGNED_BIT = 1;
  localparam int DIV_REM_BIT    = 0;

  localparam int DIV_ITERS = 32;
  localparam int DIV_CNT_W = $clog2(DIV_ITERS);

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_CALC_ENC = 2'd1;
  localparam logic [1:0] ST_FIX_ENC  = 2'd2;
  localparam logic [1:0] ST_DONE_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_CALC = ST_CALC_ENC,
    ST_FIX  = ST_FIX_ENC,
    ST_DONE = ST_DONE_ENC
  } div_state_e;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration, purely combinational: shift {rem, quo} left,
// trial-subtract the divisor magnitude, keep the difference when it does not borrow.
module div_restore_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor_mag,
  output logic [XLEN-1:0] rem_nxt,
  output logic [XLEN-1:0] quo_nxt
);

  logic [XLEN:0] rem_sh;
  logic [XLEN:0] trial;
  logic          borrow;

  // rem < divisor_mag always holds, so the 33-bit difference's top bit is the borrow.
  assign rem_sh  = {rem, quo[XLEN-1]};
  assign trial   = rem_sh - {1'b0, divisor_mag};
  assign borrow  = trial[XLEN];
  assign rem_nxt = borrow ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
  assign quo_nxt = {quo[XLEN-2:0], ~borrow};

endmodule

// File: rtl/ex_div_seq.sv
// RV32M divide sequencer: 34-cycle restoring path, 1-cycle special cases; done held until out_ready.
// Optional EX_DIV_EARLY_OUT_EN: divisor magnitude > dividend magnitude also finishes in 1 cycle.
module ex_div_seq
  import ex_div_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  input  logic            out_ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e             state_q, state_d;
  logic [DIV_CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]             op_q, op_d;
  logic [XLEN-1:0]        dmag_q, dmag_d;
  logic [XLEN-1:0]        rem_q, rem_d;
  logic [XLEN-1:0]        quo_q, quo_d;
  logic                   q_neg_q, q_neg_d;
  logic                   r_neg_q, r_neg_d;
  logic [XLEN-1:0]        result_q, result_d;

  logic                   is_signed;
  logic [XLEN-1:0]        a_mag, b_mag;
  logic [XLEN-1:0]        step_rem, step_quo;
  logic [XLEN-1:0]        q_fix, r_fix;

  div_restore_step #(.XLEN(XLEN)) u_step (
    .rem         (rem_q),
    .quo         (quo_q),
    .divisor_mag (dmag_q),
    .rem_nxt     (step_rem),
    .quo_nxt     (step_quo)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    dmag_d   = dmag_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    result_d = result_q;

    is_signed = op[DIV_SIGNED_BIT];
    a_mag = (is_signed && dividend[XLEN-1]) ? -dividend : dividend;
    b_mag = (is_signed && divisor[XLEN-1])  ? -divisor  : divisor;
    q_fix = q_neg_q ? -quo_q : quo_q;
    r_fix = r_neg_q ? -rem_q : rem_q;

    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_d    = op;
            dmag_d  = b_mag;
            rem_d   = '0;
            quo_d   = a_mag;
            q_neg_d = is_signed & (dividend[XLEN-1] ^ divisor[XLEN-1]);
            r_neg_d = is_signed & dividend[XLEN-1];
            cnt_d   = '0;
            if (divisor == '0) begin
              result_d = op[DIV_REM_BIT] ? dividend : '1;
              state_d  = ST_DONE;
            end else if (is_signed && dividend == INT_MIN && divisor == '1) begin
              result_d = op[DIV_REM_BIT] ? '0 : INT_MIN;
              state_d  = ST_DONE;
`ifdef EX_DIV_EARLY_OUT_EN
            end else if (b_mag > a_mag) begin
              result_d = op[DIV_REM_BIT] ? dividend : '0;
              state_d  = ST_DONE;
`endif
            end else begin
              state_d = ST_CALC;
            end
          end
        end
        ST_CALC: begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == DIV_CNT_W'(DIV_ITERS - 1)) state_d = ST_FIX;
        end
        ST_FIX: begin
          result_d = op_q[DIV_REM_BIT] ? r_fix : q_fix;
          state_d  = ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      dmag_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      dmag_q   <= dmag_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;

endmodule

// File: doc/ex_div_seq.md
# ex_div_seq

Multi-cycle divide sequencer for the execute stage. It accepts one RV32M divide/remainder operation (DIV, DIVU, REM, REMU) and runs a 32-step restoring division. It holds the stage busy while iterating, then presents the result under a ready/done handshake. It sits beside the single-cycle ALU in EX; the stage's ready-go is gated by `busy` and `done`.

## Interface
Parameters:
- `XLEN`, 32, operand and result width; only 32 is supported.

Ports:
- `clk` input 1: the single clock.
- `resetn` input 1: asynchronous, active-low reset.
- `start` input 1: a valid divide op is present in EX; sampled only in IDLE.
- `op` input 2: bit1 = signed (DIV/REM), bit0 = return remainder (REM/REMU).
- `dividend` input 32: rs1 value.
- `divisor` input 32: rs2 value.
- `flush` input 1: pipeline kill; aborts any operation.
- `out_ready` input 1: downstream (EX→MEM) accepts the result this cycle.
- `busy` output 1: high in CALC and FIX.
- `done` output 1: result valid; held until accepted.
- `result` output 32: quotient or remainder per `op`.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE, `start`=1, `flush`=0:
  - Latch `op`, the operand magnitudes (abs if signed, raw if unsigned), and the result signs: q_neg = sign(a) xor sign(b); r_neg = sign(a).
  - Counter is set to 0.
  - Go to CALC.
  - Special cases bypass CALC and FIX and go directly to DONE with the final result latched:
    - divisor == 0: quotient = 0xFFFFFFFF; remainder = dividend.
    - signed, dividend == 0x80000000, divisor == 0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- CALC: one restoring step per cycle, MSB first.
  - Shift {rem, quo} left 1 and compute trial = rem − divisor_mag as a 33-bit subtraction.
  - If no borrow: rem = trial and set the quotient LSB.
  - Counter increments; after step 31 go to FIX.
- FIX: apply the sign correction (two's-complement negate of q if q_neg, of r if r_neg), select q or r by `op[0]`, write `result`, and go to DONE.
- DONE: `done`=1 and `result` is stable. If `out_ready`=1, go to IDLE next edge; `done` drops the same edge.
- `start` outside IDLE is ignored; there is no queueing.
- `flush` in any state forces IDLE at the next edge and drops `done`/`busy`; `result` is not cleared.
- `flush` and `start` in the same IDLE cycle: `flush` wins and nothing is accepted.
- `flush` with `out_ready` in DONE: go to IDLE (same outcome).

## Timing
- Reset (asynchronous assert, synchronous deassert via `clk`): state=IDLE, `busy`=0, `done`=0, `result`=0, counter=0, all internal registers=0.
- Start is accepted at edge E0.
- Normal path:
  - CALC occupies cycles 1–32 after E0; FIX is cycle 33.
  - `done` rises in cycle 34, giving a 34-cycle latency.
  - `busy` is high cycles 1–33.
- Special-case path: `done` high in cycle 1; `busy` never asserts.
- With `out_ready` held high, back-to-back ops have a throughput of one per 35 cycles. The new `start` is sampled in the IDLE cycle following DONE.
- `result` changes only on entry to DONE.

## Configuration
- `EX_DIV_EARLY_OUT_EN` defined: on accept, if divisor_mag > dividend_mag (unsigned), take the special-case path.
  - Quotient = 0; remainder = dividend (original signed value).
  - `done` in cycle 1.
- Undefined: such operands take the full 34-cycle path and produce the identical result. Only latency differs; results are bit-identical either way.

## Structure
- Shared pipeline package/header holds:
  - the `op` bit encodings (DIV_SIGNED_BIT, DIV_REM_BIT);
  - the state encoding localparams;
  - DIV_ITERS = 32.
- The FSM, counter and operand/sign registers live in `ex_div_seq`.
- One sub-module, `div_restore_step`: combinational single restoring iteration.
  - Inputs: rem, quo, divisor_mag.
  - Outputs: next rem, next quo.
  - Keeps the FSM file free of datapath arithmetic.

## Test plan
- DIVU 100 / 7, `out_ready`=1 → `done` in cycle 34, `result`=14; REMU same operands → `result`=2.
- DIV 0xFFFFFFF9 (−7) / 2 → `result`=0xFFFFFFFD (−3); REM same → 0xFFFFFFFF (−1); signs per truncation toward zero.
- DIVU 5 / 0 → `done` in cycle 1, `result`=0xFFFFFFFF; REMU 5 / 0 → `result`=5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, REM → 0.
- Flush scenario:
  - Start DIVU 1000 / 3; assert `flush` in cycle 10 → IDLE next edge with `busy`=0 and `done`=0.
  - Restart with 9 / 3 → `result`=3 in cycle 34.
- Handshake scenario:
  - Hold `out_ready`=0 for 5 cycles after `done` → `done` and `result` stable; a `start` pulse during DONE is ignored.
  - Then `out_ready`=1 → IDLE next edge.
- Async reset asserted mid-CALC → all outputs 0 immediately; with `EX_DIV_EARLY_OUT_EN` defined, DIVU 3 / 10 → `done` in cycle 1, `result`=0 (REMU → 3).
